// File: rtl/i2c_eeprom_if.sv
// Board-level I2C pins as seen by the EEPROM slave: pad input levels plus an open-drain pull-down enable.
interface i2c_eeprom_if;
  // No valid/ready handshake here: scl_i/sda_i are raw pad levels, and the bus is wired-AND.
  // sda_oe_o=1 pulls SDA low and 0 releases it to the pull-up. The slave never drives SDA high or touches SCL.
  logic scl_i;
  logic sda_i;
  logic sda_oe_o;

  modport slave  (input scl_i, input sda_i, output sda_oe_o);
  modport master (output scl_i, output sda_i, input sda_oe_o);
endinterface

// File: rtl/i2c_eeprom.sv
// 24C02-style 256x8 I2C EEPROM slave, oversampling SCL/SDA in the clk_i domain.
// It is a single-clock FSM, and its state and pointer are exposed for debug.
module i2c_eeprom #(
  parameter logic [6:0] ADDRESS   = 7'b1010_000,
  parameter int         PAGE_BITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  i2c_eeprom_if.slave bus,
  output logic [3:0]  state_o,
  output logic [7:0]  ptr_o
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_e;

  localparam logic [7:0] PAGE_MASK = 8'((1 << PAGE_BITS) - 1);

  state_e      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic [7:0]  mem_q [256];

  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  shifted, rd_byte, ptr_page_inc;
  logic        mem_we;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // Bus conditions need SCL high in both samples so an SCL edge is never mistaken for one.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign shifted      = {shift_q[6:0], sda_s};
  assign rd_byte      = mem_q[ptr_q];
  assign ptr_page_inc = (ptr_q & ~PAGE_MASK) | ((ptr_q + 8'd1) & PAGE_MASK);

  // Synchronizers reset to the idle (pulled-up) level so that reset release creates no bus event.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[0], bus.sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[ptr_q] <= shifted;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    mem_we  = 1'b0;
    if (start_det) begin
      state_d = DEV_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = shifted;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == DEV_ADDR && shifted[7:1] != ADDRESS) state_d = IDLE;
              if (state_q == WORD_ADDR) ptr_d = shifted;
              if (state_q == WR_DATA) begin
                mem_we = 1'b1;
                ptr_d  = ptr_page_inc;
              end
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            oe_d  = 1'b1;
            cnt_d = '0;
            if (state_q == DEV_ADDR)       state_d = DEV_ACK;
            else if (state_q == WORD_ADDR) state_d = WORD_ACK;
            else                           state_d = WR_ACK;
          end
        end
        DEV_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            // The R/W bit is still in shift_q[0] from the address byte.
            if (shift_q[0]) begin
              state_d = RD_DATA;
              shift_d = rd_byte;
              oe_d    = ~rd_byte[7];
            end else begin
              state_d = WORD_ADDR;
              oe_d    = 1'b0;
            end
          end
        end
        WORD_ACK, WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_DATA;
            cnt_d   = '0;
            oe_d    = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RD_ACK;
              oe_d    = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = IDLE;
            else       ptr_d   = ptr_q + 8'd1;
          end else if (scl_fall) begin
            state_d = RD_DATA;
            cnt_d   = '0;
            shift_d = rd_byte;
            oe_d    = ~rd_byte[7];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_oe_o = oe_q;
  assign state_o      = state_q;
  assign ptr_o        = ptr_q;

endmodule

// File: tb/tb_i2c_eeprom.sv
// Directed bench for i2c_eeprom: a bit-banged I2C master, an expected-byte queue for reads, and a pass/total summary.
module tb_i2c_eeprom;

  localparam int Q = 5;
  localparam logic [3:0] ST_IDLE = 4'd0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] state_dbg;
  logic [7:0] ptr_dbg;
  logic       mon_en = 1'b0;
  int         oe_hits = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic       ack;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  i2c_eeprom_if bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe_o;

  i2c_eeprom #(.ADDRESS(7'b1010_000), .PAGE_BITS(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (state_dbg),
    .ptr_o   (ptr_dbg)
  );

  always @(posedge clk) if (mon_en && bus.sda_oe_o) oe_hits++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = bus.sda_i; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic wr(input string tag, input logic [7:0] d);
    logic a;
    write_byte(d, a);
    check(tag, a, 1'b1);
  endtask

  task automatic rd(input string tag, input logic master_ack);
    logic [7:0] d;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(~master_ack);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, d, e);
  endtask

  initial begin
    // reset state
    wait_clk(4);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_oe", bus.sda_oe_o, 1'b0);
    check("rst_ptr", ptr_dbg, 8'h00);
    rst_n = 1'b1;

    // idle bus and clocking without START: never pulled low
    mon_en = 1'b1;
    wait_clk(100);
    scl_m = 1'b0; wait_clk(Q);
    write_byte(8'hA0, ack);
    mon_en = 1'b0;
    check("no_start_ack", ack, 1'b0);
    check("idle_oe_hits", oe_hits, 0);

    // write 0x55, 0xAA at 0x10, then random read
    i2c_start(); wr("w1_dev", 8'hA0); wr("w1_word", 8'h10);
    wr("w1_d0", 8'h55); wr("w1_d1", 8'hAA); i2c_stop();
    i2c_start(); wr("r1_dev", 8'hA0); wr("r1_word", 8'h10);
    i2c_start(); wr("r1_devr", 8'hA1);
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
    rd("r1_b0", 1'b1); rd("r1_b1", 1'b0); i2c_stop();
    check("r1_ptr", ptr_dbg, 8'h11);

    // page wrap: 0x1E,0x1F then back to 0x10; 0x20 untouched
    i2c_start(); wr("w2_dev", 8'hA0); wr("w2_word", 8'h20); wr("w2_d", 8'h77); i2c_stop();
    i2c_start(); wr("w3_dev", 8'hA0); wr("w3_word", 8'h1E);
    wr("w3_d0", 8'h01); wr("w3_d1", 8'h02); wr("w3_d2", 8'h03); i2c_stop();
    check("w3_ptr_wrap", ptr_dbg, 8'h11);
    i2c_start(); wr("r2_dev", 8'hA0); wr("r2_word", 8'h1E);
    i2c_start(); wr("r2_devr", 8'hA1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h77);
    rd("r2_1e", 1'b1); rd("r2_1f", 1'b1); rd("r2_20", 1'b0); i2c_stop();
    i2c_start(); wr("r3_dev", 8'hA0); wr("r3_word", 8'h10);
    i2c_start(); wr("r3_devr", 8'hA1);
    exp_q.push_back(8'h03);
    rd("r3_10", 1'b0); i2c_stop();

    // read wrap 0xFF -> 0x00
    i2c_start(); wr("w4_dev", 8'hA0); wr("w4_word", 8'hFF); wr("w4_d", 8'hC3); i2c_stop();
    i2c_start(); wr("w5_dev", 8'hA0); wr("w5_word", 8'h00); wr("w5_d", 8'h3C); i2c_stop();
    i2c_start(); wr("r4_dev", 8'hA0); wr("r4_word", 8'hFF);
    i2c_start(); wr("r4_devr", 8'hA1);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
    rd("r4_ff", 1'b1); rd("r4_00", 1'b0); i2c_stop();
    check("r4_ptr", ptr_dbg, 8'h00);

    // wrong device address: no ACK, following bytes ignored
    i2c_start();
    write_byte(8'hA2, ack); check("bad_dev_ack", ack, 1'b0);
    check("bad_dev_state", state_dbg, ST_IDLE);
    write_byte(8'h40, ack); check("ign_b0_ack", ack, 1'b0);
    write_byte(8'h12, ack); check("ign_b1_ack", ack, 1'b0);
    check("ign_ptr", ptr_dbg, 8'h00);
    i2c_stop();

    // reset while the slave drives a read bit low (mem[0x10]=0x03, bit7=0)
    i2c_start(); wr("r5_dev", 8'hA0); wr("r5_word", 8'h10);
    i2c_start(); wr("r5_devr", 8'hA1);
    check("r5_drive_low", bus.sda_oe_o, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("r5_rst_oe", bus.sda_oe_o, 1'b0);
    check("r5_rst_ptr", ptr_dbg, 8'h00);
    check("r5_rst_state", state_dbg, ST_IDLE);
    @(negedge clk); rst_n = 1'b1;
    wait_clk(10);
    i2c_start(); wr("r6_devr", 8'hA1);
    exp_q.push_back(8'h3C);
    rd("r6_cur", 1'b0); i2c_stop();
    wait_clk(10);
    check("end_state", state_dbg, ST_IDLE);
    check("end_oe", bus.sda_oe_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
